// File: rtl/exposure_timer.sv
// exposure_timer: prescaled up-counter from 0 to a target that is latched when
// a start is accepted. On the terminal tick it raises a one-cycle Ovf pulse
// and sets a sticky Done flag. It then either returns to IDLE (one-shot) or
// keeps counting (auto-reload). Stop aborts the run and Start retriggers it.
// Priority on each clock edge: Reset > Stop > Start > tick.
module exposure_timer #(
    parameter int WIDTH    = 5,
    parameter int PRESCALE = 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] Initial,
    input  logic             Start,
    input  logic             Stop,
    input  logic             Auto_reload,
    output logic [WIDTH-1:0] Current_time,
    output logic             Busy,
    output logic             Ovf,
    output logic             Done
);

    // The prescaler needs at least one bit, even when PRESCALE is 1.
    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    // Prescaler value on the edge that produces a count tick.
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] count_reg, count_next;
    logic [WIDTH-1:0] target_reg, target_next;
    logic [PRE_W-1:0] pre_reg, pre_next;
    logic             ovf_reg, ovf_next;
    logic             done_reg, done_next;

    logic tick;
    logic at_target;

    // A count tick happens when the prescaler has reached its last value.
    // With PRESCALE=1 the prescaler stays at 0, so every edge is a tick.
    assign tick      = (pre_reg == PRE_LAST);
    assign at_target = (count_reg == target_reg);

    // Next-state and next-register logic: Stop, then Start, then the RUN tick.
    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        target_next = target_reg;
        pre_next    = pre_reg;
        ovf_next    = 1'b0;
        done_next   = done_reg;

        if (Stop) begin
            // Abort: progress is lost, Done keeps its value, and no Ovf is issued.
            state_next = IDLE;
            count_next = '0;
            pre_next   = '0;
        end else if (Start) begin
            // Start, or a retrigger while running: latch a new target and count from 0.
            state_next  = RUN;
            target_next = Initial;
            count_next  = '0;
            pre_next    = '0;
            done_next   = 1'b0;
        end else begin
            unique case (state_reg)
                RUN: begin
                    if (!tick) begin
                        pre_next = pre_reg + PRE_ONE;
                    end else begin
                        pre_next = '0;
                        if (!at_target) begin
                            count_next = count_reg + CNT_ONE;
                        end else begin
                            // Terminal tick. Auto_reload is only sampled here.
                            ovf_next   = 1'b1;
                            done_next  = 1'b1;
                            count_next = '0;
                            if (!Auto_reload) begin
                                state_next = IDLE;
                            end
                        end
                    end
                end
                IDLE: begin
                    // Waiting for Start. All registers hold their values.
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers. Reset has the highest priority.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            target_reg <= '0;
            pre_reg    <= '0;
            ovf_reg    <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            target_reg <= target_next;
            pre_reg    <= pre_next;
            ovf_reg    <= ovf_next;
            done_reg   <= done_next;
        end
    end

    assign Current_time = count_reg;
    assign Busy         = (state_reg == RUN);
    assign Ovf          = ovf_reg;
    assign Done         = done_reg;

endmodule

// File: tb/tb_exposure_timer.sv
// Testbench for exposure_timer. Two instances (PRESCALE=1 and PRESCALE=3)
// share the same stimulus. An elapsed-cycle model of each instance is checked
// against the DUT outputs on every falling edge. A set of directed
// sequences with hand-computed results pins both the DUT and the model.
module tb_exposure_timer;

    localparam int W = 5;

    logic         clk;
    logic         reset;
    logic [W-1:0] initial_val;
    logic         start;
    logic         stop;
    logic         auto_reload;

    logic [W-1:0] ct1, ct3;
    logic         busy1, busy3, ovf1, ovf3, done1, done3;

    int vectors    = 0;
    int miscompares = 0;
    bit chk_en     = 0;

    exposure_timer #(.WIDTH(W), .PRESCALE(1)) u1 (
        .Clk(clk), .Reset(reset), .Initial(initial_val), .Start(start),
        .Stop(stop), .Auto_reload(auto_reload), .Current_time(ct1),
        .Busy(busy1), .Ovf(ovf1), .Done(done1)
    );

    exposure_timer #(.WIDTH(W), .PRESCALE(3)) u3 (
        .Clk(clk), .Reset(reset), .Initial(initial_val), .Start(start),
        .Stop(stop), .Auto_reload(auto_reload), .Current_time(ct3),
        .Busy(busy3), .Ovf(ovf3), .Done(done3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model. Index 0 is the PRESCALE=1 instance, index 1 is PRESCALE=3.
    // The model counts raw clock cycles since the start. The count shown is
    // elapsed/P, and the run completes when elapsed reaches (T+1)*P.
    int pres[2] = '{1, 3};
    int m_el[2];
    int m_tgt[2];
    bit m_run[2];
    bit m_ovf[2];
    bit m_done[2];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            m_ovf[i] = 1'b0;
            if (reset) begin
                m_el[i] = 0; m_tgt[i] = 0; m_run[i] = 0; m_done[i] = 0;
            end else if (stop) begin
                m_el[i] = 0; m_run[i] = 0;
            end else if (start) begin
                m_el[i] = 0; m_tgt[i] = int'(initial_val); m_run[i] = 1; m_done[i] = 0;
            end else if (m_run[i]) begin
                m_el[i] = m_el[i] + 1;
                if (m_el[i] == (m_tgt[i] + 1) * pres[i]) begin
                    m_ovf[i]  = 1'b1;
                    m_done[i] = 1'b1;
                    m_el[i]   = 0;
                    m_run[i]  = auto_reload;
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Compare every DUT output against the model on each falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("u1_ct",   int'(ct1),   m_el[0] / pres[0]);
            check("u1_busy", int'(busy1), int'(m_run[0]));
            check("u1_ovf",  int'(ovf1),  int'(m_ovf[0]));
            check("u1_done", int'(done1), int'(m_done[0]));
            check("u3_ct",   int'(ct3),   m_el[1] / pres[1]);
            check("u3_busy", int'(busy3), int'(m_run[1]));
            check("u3_ovf",  int'(ovf3),  int'(m_ovf[1]));
            check("u3_done", int'(done3), int'(m_done[1]));
        end
    end

    // Advance past the next rising edge. Outputs after that edge are then stable.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; auto_reload = 1'b0; initial_val = '0;
        repeat (3) step();
        check("rst_ct",   int'(ct1),   0);
        check("rst_busy", int'(busy3), 0);
        check("rst_done", int'(done1), 0);
        reset = 1'b0;
        chk_en = 1'b1;

        // One-shot, target 5. Changing Initial mid-run must have no effect.
        initial_val = 5; start = 1'b1; step(); start = 1'b0;   // E0
        initial_val = 2;
        repeat (5) step();                                     // E5
        check("os_ct5", int'(ct1), 5);
        check("os_no_ovf_yet", int'(ovf1), 0);
        step();                                                // E6
        check("os_ovf", int'(ovf1), 1);
        check("os_busy_fall", int'(busy1), 0);
        check("os_done", int'(done1), 1);
        check("model_os_ovf", int'(m_ovf[0]), 1);
        step();                                                // E7
        check("os_ovf_once", int'(ovf1), 0);
        check("os_done_sticky", int'(done1), 1);
        repeat (11) step();                                    // E18: P=3 instance
        check("p3_os_ovf", int'(ovf3), 1);
        check("p3_os_busy", int'(busy3), 0);
        check("model_p3_ovf", int'(m_ovf[1]), 1);

        // Auto-reload with target 2: P=3 pulses at E9, E18 and E27.
        initial_val = 2; auto_reload = 1'b1; start = 1'b1; step(); start = 1'b0;
        repeat (8) step();                                     // E8
        check("ar_ct", int'(ct3), 2);
        check("ar_no_ovf", int'(ovf3), 0);
        step();                                                // E9
        check("ar_ovf9", int'(ovf3), 1);
        check("ar_busy9", int'(busy3), 1);
        check("ar_ct9", int'(ct3), 0);
        check("ar_u1_ovf9", int'(ovf1), 1);
        repeat (9) step();                                     // E18
        check("ar_ovf18", int'(ovf3), 1);
        auto_reload = 1'b0;
        repeat (9) step();                                     // E27
        check("ar_ovf27", int'(ovf3), 1);
        check("ar_busy27", int'(busy3), 0);

        // Target 0 with P=1 and auto-reload: Ovf every cycle starting at E1.
        initial_val = 0; auto_reload = 1'b1; start = 1'b1; step(); start = 1'b0;
        step();
        check("t0_ovf1", int'(ovf1), 1);
        step();
        check("t0_ovf2", int'(ovf1), 1);
        stop = 1'b1; step(); stop = 1'b0;
        check("stop_busy", int'(busy1), 0);
        check("stop_no_ovf", int'(ovf1), 0);
        check("stop_done_kept", int'(done1), 1);

        // Reset on the terminal edge clears everything and suppresses Ovf.
        initial_val = 0; auto_reload = 1'b0; start = 1'b1; step(); start = 1'b0;
        reset = 1'b1; step(); reset = 1'b0;
        check("rst_term_ovf", int'(ovf1), 0);
        check("rst_term_busy", int'(busy1), 0);
        check("rst_term_done", int'(done1), 0);

        // Start together with Stop: Stop wins.
        start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
        check("startstop_busy", int'(busy1), 0);

        // Start on the terminal edge: no Ovf, and the count restarts.
        initial_val = 1; start = 1'b1; step(); start = 1'b0;   // E0
        step();                                                // E1
        start = 1'b1; step(); start = 1'b0;                    // E2
        check("st_term_ovf", int'(ovf1), 0);
        check("st_term_done", int'(done1), 0);
        check("st_term_ct", int'(ct1), 0);
        check("st_term_busy", int'(busy1), 1);

        // Full-scale target: the count reaches 31 without wrapping.
        initial_val = 31; start = 1'b1; step(); start = 1'b0;
        repeat (31) step();                                    // E31
        check("max_ct31", int'(ct1), 31);
        check("max_no_ovf", int'(ovf1), 0);
        step();                                                // E32
        check("max_ovf", int'(ovf1), 1);
        check("max_ct0", int'(ct1), 0);

        // Randomised traffic, checked against the model on every cycle.
        for (int n = 0; n < 4000; n++) begin
            reset       = ($urandom_range(0, 199) == 0);
            stop        = ($urandom_range(0, 59) == 0);
            start       = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 7) == 0) auto_reload = ~auto_reload;
            initial_val = ($urandom_range(0, 9) == 0) ? W'($urandom_range(0, 31))
                                                      : W'($urandom_range(0, 6));
            step();
        end
        reset = 1'b0; start = 1'b0; stop = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/exposure_timer.md
# exposure_timer

Parametrised successor of the single-shot 5-bit timer counter in the exposure-control path. Counts prescaled clock ticks up from 0 to a target latched at start, raises a one-cycle overflow pulse on completion, and either stops (one-shot) or restarts (auto-reload). Adds a clock prescaler, abort, retrigger and a sticky done flag. It sits between the control FSM (which drives Start/Stop) and the sensor readout sequencer (which consumes Ovf).

## Interface
- WIDTH, 5, counter and target width in bits (≥1)
- PRESCALE, 1, Clk cycles per count tick (≥1)

- Clk  in  1  sole clock, rising edge
- Reset  in  1  synchronous, active-high; highest priority
- Initial  in  WIDTH  target count, sampled only when a start is accepted
- Start  in  1  level-sampled start/retrigger request
- Stop  in  1  level-sampled abort request
- Auto_reload  in  1  1 = periodic, 0 = one-shot; sampled at each terminal tick
- Current_time  out  WIDTH  running count
- Busy  out  1  high while in RUN
- Ovf  out  1  one-cycle pulse at terminal count
- Done  out  1  sticky; set with Ovf, cleared by accepted Start or Reset

## Operation
- State: IDLE, RUN. Internal registers: Target[WIDTH], Pre[clog2(PRESCALE) bits, min 1].
- Reset high at an edge: state IDLE; Current_time, Target, Pre, Busy, Ovf and Done all 0.
- Per-edge priority (not in reset): Stop > Start > tick.
- Stop=1: go to IDLE with Current_time=0 and Pre=0. Ovf is not issued. Done is unchanged. This holds in both states.
- Start=1 with Stop=0, in either state: Target←Initial, Current_time←0, Pre←0, Done←0, go to RUN. In RUN this is a retrigger and discards any progress.
- RUN, no Stop or Start:
  - If Pre≠PRESCALE−1: Pre←Pre+1.
  - Otherwise (tick): Pre←0.
    - If Current_time≠Target: Current_time←Current_time+1.
    - If Current_time==Target: Ovf←1, Done←1, Current_time←0. Stay in RUN if Auto_reload=1, else go to IDLE.
- Ovf is registered and high for exactly one cycle per terminal tick. It is 0 in all other cycles.
- Busy reflects the registered state (1 in RUN).
- Arithmetic: unsigned. The count never exceeds Target, so no wrap occurs. Target=2^WIDTH−1 is legal.
- Changes to Initial while in RUN have no effect until the next accepted Start.

## Timing
- Start accepted at edge E0: Busy=1, Current_time=0 after E0.
- Current_time increments every PRESCALE edges.
- Ovf is high during the cycle after edge E0 + (Target+1)·PRESCALE.
- One-shot mode: Busy falls at that same edge.
- Auto-reload mode: Ovf period is (Target+1)·PRESCALE cycles with no gap cycles.
- Target=0, PRESCALE=1: Ovf follows the edge after E0 (latency 1) and repeats every cycle in auto-reload.
- Stop and terminal tick on the same edge: Stop wins, no Ovf.
- Start and terminal tick on the same edge: Start wins, no Ovf, count restarts.
- Reset mid-RUN: next cycle is IDLE with all outputs 0, even if a terminal tick coincided.
- Auto_reload toggled mid-run: only its value at the terminal tick matters.
- Start held high continuously: retriggers every edge, so Ovf never fires. Callers pulse Start.

## Test plan
- Basic one-shot, WIDTH=5, PRESCALE=1, Initial=5, 1-cycle Start at E0: Current_time 0..5, Ovf high only after E6, Busy falls at E6, Done=1 and stays.
- Prescale and auto-reload, PRESCALE=3, Initial=2, Auto_reload=1: Ovf pulses at E9, E18, E27; Busy stays 1; Current_time steps every 3 edges. Drop Auto_reload before E27: Busy=0 after E27.
- Boundaries:
  - Initial=0, PRESCALE=1, auto-reload: Ovf=1 every cycle from E1.
  - Initial=31, WIDTH=5: Ovf after E32, no wrap observed.
- Abort and retrigger, Initial=5, PRESCALE=1:
  - Stop at E3: Busy=0, Current_time=0, no Ovf, Done unchanged.
  - Start at E4 of a new run: count restarts, Ovf after E4+6.
  - Start+Stop together: Stop wins.
- Reset and collisions:
  - Reset asserted on the terminal edge: no Ovf, all outputs 0 next cycle.
  - Start on the terminal edge: no Ovf, Done=0, Current_time=0.
  - Initial changed mid-run from 5 to 2: Ovf still after E6.
